// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its PC register, instruction memory and decode stage.
// With FETCH_MISALIGN_CHK_EN defined the bundle also carries fetch_fault and fault_addr.
interface fetch_sequencer_if;
    logic [31:0] pc_in;
    logic        pc_load_en;
    logic [31:0] pc_load_data;
    logic        pc_inc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_fault;
    logic [31:0] fault_addr;

    modport master (
        input  pc_in, imem_ready, imem_rdata, if_ready, redirect_valid, redirect_target, halt_req,
        output pc_load_en, pc_load_data, pc_inc_en, imem_req, imem_addr,
               if_valid, if_instr, if_pc, halted, fetch_fault, fault_addr
    );

    modport slave (
        output pc_in, imem_ready, imem_rdata, if_ready, redirect_valid, redirect_target, halt_req,
        input  pc_load_en, pc_load_data, pc_inc_en, imem_req, imem_addr,
               if_valid, if_instr, if_pc, halted, fetch_fault, fault_addr
    );
`else
    modport master (
        input  pc_in, imem_ready, imem_rdata, if_ready, redirect_valid, redirect_target, halt_req,
        output pc_load_en, pc_load_data, pc_inc_en, imem_req, imem_addr,
               if_valid, if_instr, if_pc, halted
    );

    modport slave (
        output pc_in, imem_ready, imem_rdata, if_ready, redirect_valid, redirect_target, halt_req,
        input  pc_load_en, pc_load_data, pc_inc_en, imem_req, imem_addr,
               if_valid, if_instr, if_pc, halted
    );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers the PC register, runs the imem handshake and holds one instruction for decode.
// Optional FETCH_MISALIGN_CHK_EN traps misaligned redirect targets in a FAULT state instead of aligning them.
module fetch_sequencer #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [2:0] {BOOT, FETCH, HOLD, HALT, FAULT} state_t;
`else
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALT} state_t;
`endif

    state_t      state_q, state_d;
    logic        redirPend_q, redirPend_d;
    logic [31:0] redirTgt_q, redirTgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instrPc_q, instrPc_d;
    logic [31:0] tgtSel;
    logic [31:0] loadAddr;
    logic        redirAct;
    logic        loadEn;
    logic        incEn;
    logic        reqOut;
    logic        validOut;
`ifdef FETCH_MISALIGN_CHK_EN
    logic [31:0] faultAddr_q, faultAddr_d;
    logic        tgtBad;
`endif

    always_comb begin
        state_d     = state_q;
        redirPend_d = redirPend_q;
        redirTgt_d  = redirTgt_q;
        instr_d     = instr_q;
        instrPc_d   = instrPc_q;
        redirAct    = 1'b0;
        loadEn      = 1'b0;
        incEn       = 1'b0;
        reqOut      = 1'b0;
        validOut    = 1'b0;
        // A live redirect always beats one latched earlier in the same fetch.
        tgtSel      = bus.redirect_valid ? bus.redirect_target : redirTgt_q;
        loadAddr    = (state_q == BOOT) ? BOOT_ADDR : (tgtSel & ~32'h3);
`ifdef FETCH_MISALIGN_CHK_EN
        faultAddr_d = faultAddr_q;
        tgtBad      = (tgtSel[1:0] != 2'b00);
`endif

        unique case (state_q)
            BOOT: begin
                loadEn  = rst_n;
                state_d = FETCH;
            end
            FETCH: begin
                reqOut = 1'b1;
                if (bus.imem_ready) begin
                    if (bus.redirect_valid || redirPend_q) begin
                        redirAct    = 1'b1;
                        redirPend_d = 1'b0;
                    end else begin
                        instr_d   = bus.imem_rdata;
                        instrPc_d = bus.pc_in;
                        incEn     = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    redirPend_d = 1'b1;
                    redirTgt_d  = bus.redirect_target;
                end
            end
            HOLD: begin
                validOut = ~bus.redirect_valid;
                if (bus.redirect_valid) begin
                    redirAct = 1'b1;
                    state_d  = FETCH;
                end else if (bus.if_ready) begin
                    state_d = bus.halt_req ? HALT : FETCH;
                end
            end
            HALT: begin
                if (bus.redirect_valid) begin
                    redirAct = 1'b1;
                end else if (!bus.halt_req) begin
                    state_d = FETCH;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            FAULT: begin
                if (bus.redirect_valid) begin
                    redirAct = 1'b1;
                    state_d  = FETCH;
                end
            end
`endif
            default: state_d = BOOT;
        endcase

        // Resolve the redirect once: either load the PC or, when checking, trap the bad target.
        if (redirAct) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (tgtBad) begin
                state_d     = FAULT;
                faultAddr_d = tgtSel;
            end else begin
                loadEn = 1'b1;
            end
`else
            loadEn = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            redirPend_q <= 1'b0;
            redirTgt_q  <= '0;
            instr_q     <= '0;
            instrPc_q   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            faultAddr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            redirPend_q <= redirPend_d;
            redirTgt_q  <= redirTgt_d;
            instr_q     <= instr_d;
            instrPc_q   <= instrPc_d;
`ifdef FETCH_MISALIGN_CHK_EN
            faultAddr_q <= faultAddr_d;
`endif
        end
    end

    assign bus.pc_load_en   = loadEn;
    assign bus.pc_load_data = loadEn ? loadAddr : 32'h0;
    assign bus.pc_inc_en    = incEn;
    assign bus.imem_req     = reqOut;
    assign bus.imem_addr    = reqOut ? bus.pc_in : 32'h0;
    assign bus.if_valid     = validOut;
    assign bus.if_instr     = instr_q;
    assign bus.if_pc        = instrPc_q;
    assign bus.halted       = (state_q == HALT);
`ifdef FETCH_MISALIGN_CHK_EN
    assign bus.fetch_fault  = (state_q == FAULT);
    assign bus.fault_addr   = faultAddr_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: the expected instruction stream is rebuilt from program
// order (boot address, +4 per accepted instruction, restart at each redirect) and checked by a negedge monitor.
module tb_fetch_sequencer;
    localparam logic [31:0] BootAddr  = 32'h0000_0100;
    localparam int          RunCycles = 1500;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    int          deliveries;
    logic        armed;
    logic        expectHalt;
    logic        lastStall;
    logic [31:0] lastAddr;
    fetch_t      expQ[$];

    fetch_sequencer_if bus();

    fetch_sequencer #(.BOOT_ADDR(BootAddr)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory contents are a fixed function of the address.
    assign bus.imem_rdata = memWord(bus.imem_addr);

    // PC register the sequencer steers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                bus.pc_in <= 32'h0;
        else if (bus.pc_load_en)   bus.pc_in <= bus.pc_load_data;
        else if (bus.pc_inc_en)    bus.pc_in <= bus.pc_in + 32'd4;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expectStream(input logic [31:0] start);
        expQ.delete();
        for (int i = 0; i < 8; i++)
            expQ.push_back('{pc: start + 32'(4 * i), instr: memWord(start + 32'(4 * i))});
    endtask

    task automatic extendStream();
        logic [31:0] nxt;
        while (expQ.size() < 8 && expQ.size() > 0) begin
            nxt = expQ[$].pc + 32'd4;
            expQ.push_back('{pc: nxt, instr: memWord(nxt)});
        end
    endtask

    // Monitor: checks handshake invariants and pops the scoreboard on every accepted instruction.
    always @(negedge clk) begin
        fetch_t exp;
        if (!rst_n || !armed) begin
            lastStall  = 1'b0;
            expectHalt = 1'b0;
        end else begin
            if (bus.pc_load_en || bus.pc_inc_en)
                checkOutput("loadIncExclusive", {31'b0, bus.pc_load_en & bus.pc_inc_en}, 32'd0);
            if (bus.imem_req)
                checkOutput("imemAddrIsPc", bus.imem_addr, bus.pc_in);
            if (lastStall)
                checkOutput("reqAddrStable", {bus.imem_req, bus.imem_addr[30:0]}, {1'b1, lastAddr[30:0]});
            if (bus.redirect_valid)
                checkOutput("validDropOnRedirect", {31'b0, bus.if_valid}, 32'd0);
            if (expectHalt) begin
                checkOutput("haltedAfterDelivery", {30'b0, bus.halted, bus.imem_req}, 32'd2);
                expectHalt = 1'b0;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            if (expQ.size() > 0)
                checkOutput("noSpuriousFault", {31'b0, bus.fetch_fault}, 32'd0);
`endif
            if (bus.if_valid && bus.if_ready) begin
                deliveries++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedDelivery actual=%h required=none", bus.if_pc);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("deliveredPc", bus.if_pc, exp.pc);
                    checkOutput("deliveredInstr", bus.if_instr, exp.instr);
                    extendStream();
                end
                if (bus.halt_req) expectHalt = 1'b1;
            end
            lastStall = bus.imem_req & ~bus.imem_ready;
            lastAddr  = bus.imem_addr;
        end
    end

    task automatic checkResetOutputs();
        checkOutput("rstStrobes", {27'b0, bus.pc_load_en, bus.pc_inc_en, bus.imem_req, bus.if_valid, bus.halted}, 32'd0);
        checkOutput("rstImemAddr", bus.imem_addr, 32'h0);
        checkOutput("rstIfInstr", bus.if_instr, 32'h0);
        checkOutput("rstIfPc", bus.if_pc, 32'h0);
        checkOutput("rstPcLoadData", bus.pc_load_data, 32'h0);
    endtask

    task automatic bootSequence();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("bootLoadEn", {31'b0, bus.pc_load_en}, 32'd1);
        checkOutput("bootLoadData", bus.pc_load_data, BootAddr);
        expectStream(BootAddr);
        armed = 1'b1;
        @(negedge clk);
        checkOutput("bootFetchAddr", {bus.imem_req, bus.imem_addr[30:0]}, {1'b1, BootAddr[30:0]});
    endtask

    task automatic applyStimulus(input int cycles);
        logic [31:0] tgt;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            bus.imem_ready     = ($urandom_range(0, 2) != 0);
            bus.if_ready       = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 14) == 0);
            if (!bus.halt_req)     bus.halt_req = ($urandom_range(0, 39) == 0);
            else if (bus.halted)   bus.halt_req = ($urandom_range(0, 2) != 0);
            if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
                tgt = 32'h1000 + 32'($urandom_range(0, 1023) * 4);
`else
                tgt = 32'h1000 + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(0, 3));
`endif
                bus.redirect_target = tgt;
                expectStream(tgt & ~32'h3);
            end
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int waitCycles;
        checks = 0;
        errors = 0;
        deliveries = 0;
        armed = 1'b0;
        rst_n = 1'b0;
        bus.imem_ready = 1'b0;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        bus.halt_req = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        bootSequence();
        applyStimulus(RunCycles);

        // Abandon an outstanding request with an asynchronous reset.
        bus.halt_req = 1'b0;
        bus.imem_ready = 1'b0;
        waitCycles = 0;
        while (!bus.imem_req && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("reqBeforeReset", {31'b0, bus.imem_req}, 32'd1);
        #2;
        armed = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        bus.imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        bus.imem_ready = 1'b0;
        bootSequence();
        applyStimulus(RunCycles);

        // Redirect to an unaligned target with every handshake ready.
        @(posedge clk);
        #1;
        bus.halt_req = 1'b0;
        bus.if_ready = 1'b1;
        bus.imem_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h202;
`ifdef FETCH_MISALIGN_CHK_EN
        expQ.delete();
        @(negedge clk);
        checkOutput("misalignNoLoad", {31'b0, bus.pc_load_en}, 32'd0);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        checkOutput("faultFlag", {30'b0, bus.fetch_fault, bus.imem_req}, 32'd2);
        checkOutput("faultAddr", bus.fault_addr, 32'h202);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h300;
        expectStream(32'h300);
        @(negedge clk);
        checkOutput("faultExitLoad", bus.pc_load_data, 32'h300);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        checkOutput("faultCleared", {31'b0, bus.fetch_fault}, 32'd0);
`else
        expectStream(32'h200);
        @(negedge clk);
        checkOutput("alignedLoadData", {bus.pc_load_en, bus.pc_load_data[30:0]}, {1'b1, 31'h200});
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
`endif
        applyStimulus(200);

        checkOutput("enoughDeliveries", {31'b0, deliveries >= 100}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
